// File: rtl/bcd_scan_pkg.sv
// Shared constants, scan-state encoding and helpers for the BCD scan counter.
// Leading-zero blanking is compiled in by defining BCD_SCAN_LZB_EN.
package bcd_scan_pkg;

   localparam int         NUM_DIGITS    = 4;
   localparam logic [3:0] BCD_MAX       = 4'd9;
   localparam logic [3:0] DIG_SEL_RESET = 4'b1110;
   localparam int         PRESC_W       = 16;

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } scan_state_t;

   function automatic scan_state_t next_scan_state(input scan_state_t s);
      scan_state_t n;
      case (s)
         DIG0:    n = DIG1;
         DIG1:    n = DIG2;
         DIG2:    n = DIG3;
         default: n = DIG0;
      endcase
      return n;
   endfunction

   // Active-low one-hot enable for the digit a state drives.
   function automatic logic [3:0] sel_for_state(input scan_state_t s);
      logic [3:0] sel;
      case (s)
         DIG0:    sel = 4'b1110;
         DIG1:    sel = 4'b1101;
         DIG2:    sel = 4'b1011;
         default: sel = 4'b0111;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: counts 0..9 on carry-in, carry-out is combinational so a
// whole chain of decades rolls over in a single cycle.
module bcd_digit
   import bcd_scan_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       cin,
   output logic [3:0] digit,
   output logic       cout
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;
   logic       at_max;

   // Anything at or above nine wraps, so an out-of-range code can never persist.
   assign at_max = (digit_q >= BCD_MAX);

   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = 4'd0;
      end else if (cin) begin
         digit_d = at_max ? 4'd0 : (digit_q + 4'd1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit = digit_q;
   assign cout  = cin & at_max;

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-decade BCD counter with a multiplexed 7-segment scan driver.
// Define BCD_SCAN_LZB_EN to compile in leading-zero blanking.
module bcd_scan_counter
   import bcd_scan_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] value,
   output logic [3:0]  bcd,
   output logic [3:0]  dig_sel,
   output logic        carry_out,
   output logic        blank
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

   logic [NUM_DIGITS-1:0][3:0] digits;
   logic [NUM_DIGITS:0]        carry;

   logic                carry_out_q;
   logic                carry_out_d;
   logic [PRESC_W-1:0]  presc_q;
   logic [PRESC_W-1:0]  presc_d;
   scan_state_t         state_q;
   scan_state_t         state_d;
   logic [3:0]          dig_sel_q;
   logic [3:0]          dig_sel_d;
   logic                blank_w;

   assign carry[0] = inc;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_decade
      bcd_digit u_digit (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (clr),
         .cin   (carry[i]),
         .digit (digits[i]),
         .cout  (carry[i+1])
      );
   end

   assign value = digits;

   // A clear in the same cycle as a wrap suppresses the carry pulse.
   always_comb begin
      carry_out_d = carry[NUM_DIGITS] & ~clr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_out_q <= 1'b0;
      end else begin
         carry_out_q <= carry_out_d;
      end
   end

   assign carry_out = carry_out_q;

   always_comb begin
      presc_d   = presc_q;
      state_d   = state_q;
      dig_sel_d = dig_sel_q;
      if (presc_q == PRESC_LAST) begin
         presc_d   = '0;
         state_d   = next_scan_state(state_q);
         dig_sel_d = sel_for_state(next_scan_state(state_q));
      end else begin
         presc_d   = presc_q + PRESC_W'(1);
      end
   end

   // Scan FSM: the enable pattern is registered together with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         state_q   <= DIG0;
         dig_sel_q <= DIG_SEL_RESET;
      end else begin
         presc_q   <= presc_d;
         state_q   <= state_d;
         dig_sel_q <= dig_sel_d;
      end
   end

   always_comb begin
      bcd = digits[0];
      case (state_q)
         DIG0:    bcd = digits[0];
         DIG1:    bcd = digits[1];
         DIG2:    bcd = digits[2];
         default: bcd = digits[3];
      endcase
   end

`ifdef BCD_SCAN_LZB_EN
   // A digit is dark when it and every more significant digit are zero.
   always_comb begin
      blank_w = 1'b0;
      case (state_q)
         DIG1:    blank_w = (value[15:4]  == 12'd0);
         DIG2:    blank_w = (value[15:8]  == 8'd0);
         DIG3:    blank_w = (value[15:12] == 4'd0);
         default: blank_w = 1'b0;
      endcase
   end
`else
   assign blank_w = 1'b0;
`endif

   assign blank   = blank_w;
   assign dig_sel = blank_w ? 4'b1111 : dig_sel_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomised self-checking bench for bcd_scan_counter with SCAN_DIV=4,
// compared every cycle against a decimal arithmetic model.
module tb_bcd_scan_counter;

   localparam int SCAN_DIV = 4;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        inc;
   logic [15:0] value;
   logic [3:0]  bcd;
   logic [3:0]  dig_sel;
   logic        carry_out;
   logic        blank;

   int checks = 0;
   int errors = 0;

   // Model state: decimal count, pending carry pulse, cycles since reset release.
   int m_val   = 0;
   bit m_carry = 0;
   int m_cyc   = 0;

   bcd_scan_counter #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .inc       (inc),
      .value     (value),
      .bcd       (bcd),
      .dig_sel   (dig_sel),
      .carry_out (carry_out),
      .blank     (blank)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int p10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   function automatic int model_idx();
      return (m_cyc / SCAN_DIV) % 4;
   endfunction

   function automatic logic model_blank();
`ifdef BCD_SCAN_LZB_EN
      return (model_idx() > 0) && ((m_val / p10(model_idx())) == 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] model_sel();
      if (model_blank()) return 4'b1111;
      return 4'b1111 & ~(4'b0001 << model_idx());
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic c, input logic i, input int n);
      clr = c;
      inc = i;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      clr = 1'b0;
      inc = 1'b0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_val   = 0;
         m_carry = 0;
         m_cyc   = 0;
      end else begin
         m_cyc++;
         if (clr) begin
            m_val   = 0;
            m_carry = 0;
         end else if (inc) begin
            m_carry = (m_val == 9999);
            m_val   = (m_val + 1) % 10000;
         end else begin
            m_carry = 0;
         end
      end
   end

   always @(negedge clk) begin
      checkOutput("value",     value,            to_bcd(m_val));
      checkOutput("bcd",       16'(bcd),         16'((m_val / p10(model_idx())) % 10));
      checkOutput("dig_sel",   16'(dig_sel),     16'(model_sel()));
      checkOutput("carry_out", 16'(carry_out),   16'(m_carry));
      checkOutput("blank",     16'(blank),       16'(model_blank()));
   end

   logic [3:0] sel_tab [4];
   logic [3:0] lzb_sel [4];
   logic [3:0] lzb_bcd [4];
   logic       lzb_blk [4];

   initial begin
      bit found;
      sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      lzb_bcd = '{4'd0, 4'd4, 4'd0, 4'd0};
`ifdef BCD_SCAN_LZB_EN
      lzb_sel = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
      lzb_blk = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
      lzb_sel = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      lzb_blk = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

      rst_n = 1'b0;
      clr   = 1'b0;
      inc   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_value",   value,           16'h0000);
      checkOutput("rst_dig_sel", 16'(dig_sel),    16'h000E);
      checkOutput("rst_carry",   16'(carry_out),  16'h0000);
      rst_n = 1'b1;

      // Idle scan: four-cycle steps through the digit enables.
      for (int k = 0; k < 16; k++) begin
`ifdef BCD_SCAN_LZB_EN
         checkOutput("idle_dig_sel", 16'(dig_sel), (k < 4) ? 16'h000E : 16'h000F);
`else
         checkOutput("idle_dig_sel", 16'(dig_sel), 16'(sel_tab[k/4]));
`endif
         checkOutput("idle_bcd", 16'(bcd), 16'h0000);
         @(posedge clk);
         #1;
      end

      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 9);
      checkOutput("set_0009", value, 16'h0009);
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("dec_carry_value", value, 16'h0010);
      checkOutput("dec_carry_co",    16'(carry_out), 16'h0000);

      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 123);
      checkOutput("set_0123", value, 16'h0123);
      applyStimulus(1'b1, 1'b1, 1);
      checkOutput("clr_inc_value", value, 16'h0000);
      checkOutput("clr_inc_co",    16'(carry_out), 16'h0000);

      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 9999);
      checkOutput("set_9999", value, 16'h9999);
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("wrap_value", value, 16'h0000);
      checkOutput("wrap_co",    16'(carry_out), 16'h0001);
      @(posedge clk);
      #1;
      checkOutput("wrap_co_after", 16'(carry_out), 16'h0000);

      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 40);
      for (int k = 0; k < 16; k++) begin
         checkOutput("lzb_dig_sel", 16'(dig_sel), 16'(lzb_sel[model_idx()]));
         checkOutput("lzb_bcd",     16'(bcd),     16'(lzb_bcd[model_idx()]));
         checkOutput("lzb_blank",   16'(blank),   16'(lzb_blk[model_idx()]));
         @(posedge clk);
         #1;
      end

      // Random traffic starting just below the wrap point.
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 9985);
      for (int k = 0; k < 600; k++) begin
         clr = ($urandom_range(0, 31) == 0);
         inc = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 149) == 0) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      clr = 1'b0;
      inc = 1'b0;

      // Asynchronous reset in the middle of DIG2.
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 567);
      found = 1'b0;
      for (int t = 0; t < 32 && !found; t++) begin
         if (model_idx() == 2 && (m_cyc % SCAN_DIV) == 1) found = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      checkOutput("reach_dig2", 16'(found), 16'h0001);
      checkOutput("pre_reset_value", value, 16'h0567);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_value",   value,          16'h0000);
      checkOutput("async_dig_sel", 16'(dig_sel),   16'h000E);
      checkOutput("async_bcd",     16'(bcd),       16'h0000);
      checkOutput("async_carry",   16'(carry_out), 16'h0000);
      checkOutput("async_blank",   16'(blank),     16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter: SCAN_DIV, 1000, clk cycles each digit is held selected; legal range 2..65535.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock, asynchronous assert, active-low.
REQ-004 Port: clr  input  1  synchronous clear of count value.
REQ-005 Port: inc  input  1  count-enable; each high cycle adds one.
REQ-006 Port: value  output  16  packed BCD count, digit3 in [15:12] down to digit0 in [3:0].
REQ-007 Port: bcd  output  4  selected digit, fed directly to the downstream 7-segment decoder.
REQ-008 Port: dig_sel  output  4  active-low one-hot digit enable, bit n = digit n.
REQ-009 Port: carry_out  output  1  one-cycle pulse on 9999->0000 wrap.
REQ-010 Port: blank  output  1  selected digit is to be shown dark.

Function
REQ-011 Counter SHALL be 4-decade BCD; each decade ranges 0..9 only, never A..F.
REQ-012 inc=1 SHALL increment value by one at the next edge; latency 1 cycle.
REQ-013 Decade at 9 with carry-in SHALL go to 0 and carry into the next decade in the same cycle (no ripple delay).
REQ-014 inc at 9999 SHALL wrap value to 0000 and assert carry_out for exactly the following cycle.
REQ-015 clr=1 SHALL load 0000 at the next edge; clr with inc same cycle: clr wins, no increment, carry_out=0.
REQ-016 Scan prescaler SHALL count 0..SCAN_DIV-1; on terminal count it SHALL reload 0 and advance digit index.
REQ-017 Scan FSM states DIG0->DIG1->DIG2->DIG3->DIG0, one transition per prescaler terminal; no other transitions.
REQ-018 dig_sel SHALL be 1110/1101/1011/0111 in DIG0/DIG1/DIG2/DIG3.
REQ-019 bcd SHALL equal value digit of current state, combinational from registers (same cycle as value or state change).
REQ-020 clr and inc SHALL NOT disturb prescaler or scan state.
REQ-021 carry_out SHALL be registered; no other output pulses.

Reset
REQ-022 rst_n low SHALL immediately force value=0000, state=DIG0, prescaler=0, dig_sel=1110, bcd=0, carry_out=0, blank=0.
REQ-023 First scan advance after rst_n release SHALL occur exactly SCAN_DIV cycles later.
REQ-024 Reset mid-scan or mid-carry SHALL discard all progress; no carry_out after release.

Configuration
REQ-025 Macro BCD_SCAN_LZB_EN SHALL compile in leading-zero blanking.
REQ-026 With it: blank=1 when state is DIGn (n>0) and digits n..3 are all zero; dig_sel then forced to 1111; digit0 never blanked.
REQ-027 Without it: blank tied 0 and dig_sel per REQ-018 always.

Structure
REQ-028 Package bcd_scan_pkg SHALL hold NUM_DIGITS=4, BCD_MAX=4'd9, scan state encoding, DIG_SEL_RESET=4'b1110.
REQ-029 Sub-module bcd_digit (one decade: clk, rst_n, clr, cin, digit, cout) SHALL be instantiated 4x for the counter.

Verification (bench uses SCAN_DIV=4)
REQ-030 Reset release, hold inc=0 16 cycles -> dig_sel cycles 1110,1101,1011,0111 at 4-cycle steps; bcd=0 throughout.
REQ-031 Set 0009, inc one cycle -> value=0010 next edge, carry_out=0.
REQ-032 Set 9999, inc one cycle -> value=0000 and carry_out=1 one cycle only.
REQ-033 clr and inc together at 0123 -> value=0000, carry_out=0, scan phase unchanged.
REQ-034 With BCD_SCAN_LZB_EN, value=0040 -> DIG0 bcd=0 shown, DIG1 bcd=4 shown, DIG2/DIG3 blank=1, dig_sel=1111.
REQ-035 rst_n low mid-DIG2 at value 0567 -> all outputs at REQ-022 values the same cycle, asynchronously.
